// File: rtl/imm_instr_encoder.sv
// RV32I instruction encoder: biased core-view immediate + fields -> 32-bit word, 2-stage valid/ready pipeline.
// Optional `ROUNDTRIP_CHECK_EN adds a re-decode of each OK word and a sticky rt_mismatch output.
module imm_instr_encoder #(
  parameter int CNT_W  = 16,
  parameter int B_BIAS = 8,
  parameter int U_BIAS = 4,
  parameter int J_BIAS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
`ifdef ROUNDTRIP_CHECK_EN
  , output logic           rt_mismatch
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, ready never looks at valid, and a held word stays unchanged.
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

  localparam logic [1:0]  ERR_OK = 2'b00, ERR_RANGE = 2'b01, ERR_ALIGN = 2'b10, ERR_OPCODE = 2'b11;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic             s1_valid_q, s1_valid_d;
  fmt_e             s1_fmt_q, s1_fmt_d;
  logic [31:0]      s1_e_q, s1_e_d;
  logic [1:0]       s1_err_q, s1_err_d;
  logic [6:0]       s1_op_q, s1_op_d;
  logic [4:0]       s1_rd_q, s1_rd_d;
  logic [4:0]       s1_rs1_q, s1_rs1_d;
  logic [4:0]       s1_rs2_q, s1_rs2_d;
  logic [2:0]       s1_f3_q, s1_f3_d;
  logic [6:0]       s1_f7_q, s1_f7_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [1:0]       out_err_q, out_err_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic        s2_adv, accept, out_fire;
  fmt_e        in_fmt;
  logic [31:0] in_bias, in_e;
  logic        align_bad, range_bad;
  logic [31:0] pack_instr;

  assign s2_adv    = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

  // Stage 1 front end: format decode, bias restore, error classification.
  always_comb begin
    in_fmt    = FMT_X;
    in_bias   = 32'd0;
    align_bad = 1'b0;
    range_bad = 1'b0;
    case (in_opcode)
      7'b0110011:                         in_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: in_fmt = FMT_I;
      7'b0100011:                         in_fmt = FMT_S;
      7'b1100011: begin in_fmt = FMT_B; in_bias = 32'(B_BIAS); end
      7'b0110111, 7'b0010111: begin in_fmt = FMT_U; in_bias = 32'(U_BIAS); end
      7'b1101111: begin in_fmt = FMT_J; in_bias = 32'(J_BIAS); end
      default:                            in_fmt = FMT_X;
    endcase
    in_e = in_imm + in_bias;
    case (in_fmt)
      FMT_I, FMT_S: range_bad = !((&in_e[31:11]) || !(|in_e[31:11]));
      FMT_B: begin
        align_bad = in_e[0];
        range_bad = !((&in_e[31:12]) || !(|in_e[31:12]));
      end
      FMT_J: begin
        align_bad = in_e[0];
        range_bad = !((&in_e[31:20]) || !(|in_e[31:20]));
      end
      FMT_U:   align_bad = |in_e[11:0];
      default: ;
    endcase
    if (in_fmt == FMT_X)  s1_err_d = ERR_OPCODE;
    else if (align_bad)   s1_err_d = ERR_ALIGN;
    else if (range_bad)   s1_err_d = ERR_RANGE;
    else                  s1_err_d = ERR_OK;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fmt_d   = s1_fmt_q;
    s1_e_d     = s1_e_q;
    s1_op_d    = s1_op_q;
    s1_rd_d    = s1_rd_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_f3_d    = s1_f3_q;
    s1_f7_d    = s1_f7_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_fmt_d   = in_fmt;
      s1_e_d     = in_e;
      s1_op_d    = in_opcode;
      s1_rd_d    = in_rd;
      s1_rs1_d   = in_rs1;
      s1_rs2_d   = in_rs2;
      s1_f3_d    = in_funct3;
      s1_f7_d    = in_funct7;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 packing; any error collapses the word to a NOP.
  always_comb begin
    pack_instr = NOP;
    case (s1_fmt_q)
      FMT_R: pack_instr = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_I: pack_instr = {s1_e_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      FMT_S: pack_instr = {s1_e_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_e_q[4:0], s1_op_q};
      FMT_B: pack_instr = {s1_e_q[12], s1_e_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                           s1_e_q[4:1], s1_e_q[11], s1_op_q};
      FMT_U: pack_instr = {s1_e_q[31:12], s1_rd_q, s1_op_q};
      FMT_J: pack_instr = {s1_e_q[20], s1_e_q[10:1], s1_e_q[11], s1_e_q[19:12], s1_rd_q, s1_op_q};
      default: pack_instr = NOP;
    endcase
    if (s1_err_q != ERR_OK) pack_instr = NOP;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = pack_instr;
        out_err_d   = s1_err_q;
      end
    end
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (out_fire) begin
      if (!(&enc_count_q)) enc_count_d = enc_count_q + 1'b1;
      if ((out_err_q != ERR_OK) && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= FMT_X;
      s1_e_q      <= '0;
      s1_err_q    <= ERR_OK;
      s1_op_q     <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_f3_q     <= '0;
      s1_f7_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= ERR_OK;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_e_q      <= s1_e_d;
      s1_err_q    <= s1_err_d;
      s1_op_q     <= s1_op_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_f3_q     <= s1_f3_d;
      s1_f7_q     <= s1_f7_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef ROUNDTRIP_CHECK_EN
  logic [31:0] s1_imm_q, s1_imm_d;
  logic [31:0] s2_imm_q, s2_imm_d;
  logic        rt_mismatch_q, rt_mismatch_d;
  logic [31:0] dec_imm;
  logic        dec_chk;

  // Re-decode with the core extender's rules, including the bias it subtracts.
  always_comb begin
    dec_imm = '0;
    dec_chk = 1'b1;
    case (out_instr_q[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        dec_imm = {{20{out_instr_q[31]}}, out_instr_q[31:20]};
      7'b0100011:
        dec_imm = {{20{out_instr_q[31]}}, out_instr_q[31:25], out_instr_q[11:7]};
      7'b1100011:
        dec_imm = {{19{out_instr_q[31]}}, out_instr_q[31], out_instr_q[7], out_instr_q[30:25],
                   out_instr_q[11:8], 1'b0} - 32'(B_BIAS);
      7'b0110111, 7'b0010111:
        dec_imm = {out_instr_q[31:12], 12'b0} - 32'(U_BIAS);
      7'b1101111:
        dec_imm = {{11{out_instr_q[31]}}, out_instr_q[31], out_instr_q[19:12], out_instr_q[20],
                   out_instr_q[30:21], 1'b0} - 32'(J_BIAS);
      default: dec_chk = 1'b0;
    endcase
    s1_imm_d      = accept ? in_imm : s1_imm_q;
    s2_imm_d      = (s2_adv && s1_valid_q) ? s1_imm_q : s2_imm_q;
    rt_mismatch_d = rt_mismatch_q;
    if (out_fire && (out_err_q == ERR_OK) && dec_chk && (dec_imm != s2_imm_q))
      rt_mismatch_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_imm_q      <= '0;
      s2_imm_q      <= '0;
      rt_mismatch_q <= 1'b0;
    end else begin
      s1_imm_q      <= s1_imm_d;
      s2_imm_q      <= s2_imm_d;
      rt_mismatch_q <= rt_mismatch_d;
    end
  end

  assign rt_mismatch = rt_mismatch_q;
`endif

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Directed bench for imm_instr_encoder: hand-computed words checked through an expected queue,
// plus latency, backpressure, reset-while-full and counter saturation (counters narrowed to 4 bits).
module tb_imm_instr_encoder;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid, out_ready;
  logic [31:0]   out_instr;
  logic [1:0]    out_err;
  logic [CW-1:0] enc_count, err_count;
`ifdef ROUNDTRIP_CHECK_EN
  logic          rt_mismatch;
`endif

  imm_instr_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
`ifdef ROUNDTRIP_CHECK_EN
    , .rt_mismatch(rt_mismatch)
`endif
  );

  // Clock / timeout
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_enc  = 0;
  int          exp_err  = 0;
  logic [33:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every output handshake is compared against the expected queue.
  always @(negedge clk) begin
    logic [33:0] ex;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_output: observed %h expected none", out_instr);
      end else begin
        ex = exp_q.pop_front();
        chk("out_instr", out_instr, ex[31:0]);
        chk("out_err", 32'(out_err), 32'(ex[33:32]));
        if (exp_enc < (1 << CW) - 1) exp_enc++;
        if (ex[33:32] != 2'b00 && exp_err < (1 << CW) - 1) exp_err++;
      end
    end
  end

  // Driver: present a request, hold until accepted (bounded), queue its expected result.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] ei, input logic [1:0] ee);
    int n = 0;
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout: observed in_ready 0 expected 1");
    end else begin
      @(posedge clk);
      exp_q.push_back({ee, ei});
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
    #1;
  endtask

  logic [31:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADDI x1,x0,-1: two edges from accept to out_valid
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'b00);
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    chk("lat_edge2_instr", out_instr, 32'hFFF0_0093);
    drain();

    // Back-to-back directed vectors
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'h0000_0063, 2'b00);
    send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 32'h0080_006F, 2'b00);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_4FFC, 32'h1234_52B7, 2'b00);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h0000_0013, 2'b10);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0000_0013, 2'b01);
    send(7'b1110011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'h0000_0013, 2'b11);
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF9, 32'h0000_0013, 2'b10);
    send(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE51_2E23, 2'b00);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0001_2345, 32'h0020_81B3, 2'b00);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd8,         32'h0020_9863, 2'b00);
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF4, 32'hFE00_0EE3, 2'b00);
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4088,      32'h0000_0013, 2'b01);
    send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_7FFF, 32'h0000_0013, 2'b10);
    send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFF8, 32'h0000_0013, 2'b01);
    send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFF6, 32'h7FFF_F06F, 2'b00);
    send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF0, 32'hFF9F_F06F, 2'b00);
    send(7'b0010111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'h0000_0097, 2'b00);
    send(7'b0000011, 5'd10, 5'd2, 5'd0, 3'd2, 7'd0, 32'd2047,     32'h7FF1_2503, 2'b00);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 2'b00);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F7FF, 32'h0000_0013, 2'b01);
    send(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd2048,      32'h0000_0013, 2'b01);
    send(7'b1100111, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0, 32'd4,         32'h0042_80E7, 2'b00);
    send(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,         32'h0000_0013, 2'b11);
    drain();
    chk("dir_enc_count", 32'(enc_count), 32'(exp_enc));
    chk("dir_err_count", 32'(err_count), 32'(exp_err));

    // Reset with both stages full
    out_ready = 1'b0;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 2'b00);
    send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 2'b00);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_enc = 0;
    exp_err = 0;
    chk("rst_full_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full_enc_count", 32'(enc_count), 32'd0);
    chk("rst_full_err_count", 32'(err_count), 32'd0);
    chk("rst_full_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: two accepted, then stall with the head word held stable
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 2'b00);
    send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 2'b00);
    held = out_instr;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_instr", out_instr, 32'h0010_0093);
      chk("bp_stable", out_instr, held);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0FFC, 32'h0000_11B7, 2'b00);
    send(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h0040_0213, 2'b00);
    drain();
    chk("bp_enc_count", 32'(enc_count), 32'd4);
    chk("bp_err_count", 32'(err_count), 32'd0);

    // Saturation: 17 more error words on 4-bit counters
    for (int i = 0; i < 17; i++)
      send(7'b1110011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 2'b11);
    drain();
    chk("sat_enc_count", 32'(enc_count), 32'd15);
    chk("sat_err_count", 32'(err_count), 32'd15);
    chk("sat_enc_model", 32'(enc_count), 32'(exp_enc));
    chk("sat_err_model", 32'(err_count), 32'(exp_err));
`ifdef ROUNDTRIP_CHECK_EN
    chk("rt_mismatch", 32'(rt_mismatch), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
